// File: rtl/sound_pkg.sv
// Shared definitions for the sound_buzzer alarm beeper: FSM encodings,
// default timing parameters and a counter-width helper.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_HALF_PERIOD = 2;
  localparam int DEF_BEEP_ON     = 8;
  localparam int DEF_BEEP_OFF    = 4;
  localparam int DEF_BEEP_NUM    = 3;

  // Bits needed to hold values 0..v without wrapping.
  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/sound_buzzer_tone_gen.sv
// tone_gen: square-wave divider toggling buzz every HALF_PERIOD enabled cycles;
// clear forces the divider and buzz back to 0.
module tone_gen
  import sound_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic buzz
);

  localparam int            TW     = cnt_w(HALF_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);

  logic [TW-1:0] tone_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      buzz     <= 1'b0;
    end else if (clear) begin
      tone_cnt <= '0;
      buzz     <= 1'b0;
    end else if (enable) begin
      if (tone_cnt == T_LAST) begin
        tone_cnt <= '0;
        buzz     <= ~buzz;
      end else begin
        tone_cnt <= tone_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/sound_buzzer.sv
// sound_buzzer: on each rising edge of sound, plays BEEP_NUM tone bursts
// separated by silent gaps. Define SOUND_BUZZER_CNT_EN to add the alarm_cnt output.
module sound_buzzer
  import sound_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int BEEP_ON     = DEF_BEEP_ON,
  parameter int BEEP_OFF    = DEF_BEEP_OFF,
  parameter int BEEP_NUM    = DEF_BEEP_NUM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound,
  output logic       buzz,
  output logic       busy
`ifdef SOUND_BUZZER_CNT_EN
  ,
  output logic [7:0] alarm_cnt
`endif
);

  localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam int BN_W   = cnt_w(BEEP_NUM);

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF - 1);
  localparam logic [BN_W-1:0] BN_TOP   = BN_W'(BEEP_NUM);

  state_t          state, next_state;
  logic [PH_W-1:0] phase, next_phase;
  logic [BN_W-1:0] beep, next_beep;
  logic            sound_d;
  logic            trigger;
  logic            tone_clr, tone_en;

  assign trigger = sound & ~sound_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      beep    <= '0;
      sound_d <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      phase   <= next_phase;
      beep    <= next_beep;
      sound_d <= sound;
      busy    <= (next_state != IDLE);
    end
  end

  // A trigger overrides every state, so a restart mid-sequence looks identical
  // to a fresh start from IDLE.
  always_comb begin
    next_state = state;
    next_phase = phase;
    next_beep  = beep;
    tone_clr   = 1'b0;
    tone_en    = 1'b0;
    if (trigger) begin
      next_state = ON;
      next_phase = '0;
      next_beep  = BN_W'(1);
      tone_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tone_clr = 1'b1;
        end
        ON: begin
          if (phase == ON_LAST) begin
            next_phase = '0;
            tone_clr   = 1'b1;
            if (beep < BN_TOP) begin
              next_state = OFF;
            end else begin
              next_state = IDLE;
              next_beep  = '0;
            end
          end else begin
            next_phase = phase + PH_W'(1);
            tone_en    = 1'b1;
          end
        end
        OFF: begin
          tone_clr = 1'b1;
          if (phase == OFF_LAST) begin
            next_state = ON;
            next_phase = '0;
            next_beep  = beep + BN_W'(1);
          end else begin
            next_phase = phase + PH_W'(1);
          end
        end
        default: begin
          next_state = IDLE;
          next_phase = '0;
          next_beep  = '0;
          tone_clr   = 1'b1;
        end
      endcase
    end
  end

  tone_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tone_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tone_clr),
    .enable(tone_en),
    .buzz  (buzz)
  );

`ifdef SOUND_BUZZER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_cnt <= '0;
    end else if (trigger && (alarm_cnt != 8'hFF)) begin
      alarm_cnt <= alarm_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sound_buzzer.sv
// Self-checking bench for sound_buzzer: scenarios push expected busy/buzz per
// cycle into a queue; a monitor pops and compares one entry per clock.
module tb_sound_buzzer;

  localparam int HP   = 2;
  localparam int BON  = 8;
  localparam int BOFF = 4;
  localparam int BN   = 3;
  localparam int SEQ_LEN = BN * BON + (BN - 1) * BOFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sound = 1'b0;
  logic buzz, busy;
`ifdef SOUND_BUZZER_CNT_EN
  logic [7:0] alarm_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int rises = 0;
  logic prev_buzz = 1'b0;

  logic [1:0] expq[$];

  sound_buzzer #(
    .HALF_PERIOD(HP),
    .BEEP_ON    (BON),
    .BEEP_OFF   (BOFF),
    .BEEP_NUM   (BN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sound(sound),
    .buzz (buzz),
    .busy (busy)
`ifdef SOUND_BUZZER_CNT_EN
    ,
    .alarm_cnt(alarm_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected {busy,buzz} k cycles after the sequence-start edge.
  function automatic logic [1:0] exp_at(input int k);
    int pos;
    pos = k;
    for (int b = 0; b < BN; b++) begin
      if (pos < BON) return {1'b1, 1'(((pos / HP) % 2))};
      pos -= BON;
      if (b < BN - 1) begin
        if (pos < BOFF) return 2'b10;
        pos -= BOFF;
      end
    end
    return 2'b00;
  endfunction

  function automatic void push_seq(input int from, input int n);
    for (int i = from; i < from + n; i++) expq.push_back(exp_at(i));
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) expq.push_back(2'b00);
  endfunction

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      checks++;
      if (busy !== e[1]) begin
        errors++;
        $display("FAIL busy_seq t=%0t busy=%b expected=%b", $time, busy, e[1]);
      end
      checks++;
      if (buzz !== e[0]) begin
        errors++;
        $display("FAIL buzz_seq t=%0t buzz=%b expected=%b", $time, buzz, e[0]);
      end
      if (busy === 1'b1) busy_cycles++;
      if (buzz === 1'b1 && prev_buzz === 1'b0) rises++;
      prev_buzz = buzz;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sound = 1'b0;
    push_idle(4);
    wait_cycles(4);
    checks++;
    if (busy !== 1'b0 || buzz !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b buzz=%b expected=0 0", busy, buzz);
    end
    rst = 1'b0;
    push_idle(1);
    wait_cycles(1);
  endtask

  task automatic test_single_alarm();
    busy_cycles = 0;
    rises = 0;
    sound = 1'b1;
    push_seq(0, SEQ_LEN);
    push_idle(4);
    wait_cycles(4);
    sound = 1'b0;
    wait_cycles(SEQ_LEN);
    checks++;
    if (busy_cycles != SEQ_LEN) begin
      errors++;
      $display("FAIL busy_length got=%0d expected=%0d", busy_cycles, SEQ_LEN);
    end
    checks++;
    if (rises != 2 * BN) begin
      errors++;
      $display("FAIL buzz_rises got=%0d expected=%0d", rises, 2 * BN);
    end
  endtask

  task automatic test_held_sound();
    sound = 1'b1;
    push_seq(0, SEQ_LEN);
    push_idle(100 - SEQ_LEN);
    wait_cycles(100);
    sound = 1'b0;
    push_idle(3);
    wait_cycles(3);
    checks++;
    if (busy !== 1'b0 || buzz !== 1'b0) begin
      errors++;
      $display("FAIL held_end busy=%b buzz=%b expected=0 0", busy, buzz);
    end
  endtask

  task automatic test_restart();
    sound = 1'b1;
    push_seq(0, BON + 2);
    wait_cycles(2);
    sound = 1'b0;
    wait_cycles(BON);
    sound = 1'b1;
    push_seq(0, SEQ_LEN);
    push_idle(3);
    wait_cycles(1);
    sound = 1'b0;
    wait_cycles(SEQ_LEN + 2);
  endtask

  task automatic test_async_reset();
    sound = 1'b1;
    push_seq(0, 3);
    wait_cycles(1);
    sound = 1'b0;
    wait_cycles(2);
    checks++;
    if (buzz !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_buzz buzz=%b expected=1", buzz);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || buzz !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%b buzz=%b expected=0 0", busy, buzz);
    end
    push_idle(2);
    wait_cycles(2);
    rst = 1'b0;
    push_idle(5);
    wait_cycles(5);
  endtask

  task automatic test_release_with_sound();
    rst = 1'b1;
    sound = 1'b1;
    push_idle(2);
    wait_cycles(2);
    rst = 1'b0;
    push_seq(0, SEQ_LEN);
    push_idle(2);
    wait_cycles(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL release_start busy=%b expected=1", busy);
    end
    wait_cycles(1);
    sound = 1'b0;
    wait_cycles(SEQ_LEN);
  endtask

`ifdef SOUND_BUZZER_CNT_EN
  task automatic test_alarm_cnt();
    rst = 1'b1;
    sound = 1'b0;
    push_idle(2);
    wait_cycles(2);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sound = 1'b1;
      push_seq(0, SEQ_LEN);
      push_idle(2);
      wait_cycles(1);
      sound = 1'b0;
      wait_cycles(SEQ_LEN + 1);
      checks++;
      if (alarm_cnt !== 8'(p + 1)) begin
        errors++;
        $display("FAIL alarm_cnt_pulse got=%0d expected=%0d", alarm_cnt, p + 1);
      end
    end
    sound = 1'b1;
    push_seq(0, BON + 2);
    wait_cycles(1);
    sound = 1'b0;
    wait_cycles(BON + 1);
    sound = 1'b1;
    push_seq(0, SEQ_LEN);
    push_idle(1);
    wait_cycles(1);
    sound = 1'b0;
    wait_cycles(SEQ_LEN);
    checks++;
    if (alarm_cnt !== 8'd4) begin
      errors++;
      $display("FAIL alarm_cnt_total got=%0d expected=4", alarm_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_alarm();
    test_held_sound();
    test_restart();
    test_async_reset();
    test_release_with_sound();
`ifdef SOUND_BUZZER_CNT_EN
    test_alarm_cnt();
`endif
    wait_cycles(1);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_buzzer.md
SOUND_BUZZER -- requirements
Module: sound_buzzer

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2, tone half-period in clk cycles (>=1).
REQ-002 SHALL have parameter BEEP_ON, default 8, beep-on duration in clk cycles (>=1).
REQ-003 SHALL have parameter BEEP_OFF, default 4, gap between beeps in clk cycles (>=1).
REQ-004 SHALL have parameter BEEP_NUM, default 3, beeps per alarm sequence (>=1).
REQ-005 SHALL have port clk  input  1  single clock, rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port sound  input  1  alarm request level from the upstream shock_sound stage, synchronous to clk.
REQ-008 SHALL have port buzz  output  1  square-wave piezo drive, registered.
REQ-009 SHALL have port busy  output  1  high while a beep sequence runs, registered.

Function
REQ-010 SHALL register sound into sound_d each cycle; trigger = sound & ~sound_d.
REQ-011 SHALL implement FSM states IDLE, ON, OFF; busy = (state != IDLE).
REQ-012 SHALL, on the clock edge where trigger is 1 in IDLE, enter ON with beep counter 1, phase counter 0, tone counter 0, buzz 0 (busy high one cycle after sound rises).
REQ-013 SHALL, in ON, toggle buzz every HALF_PERIOD cycles, starting at 0 (default: 0,0,1,1,0,0,1,1).
REQ-014 SHALL, after BEEP_ON cycles in ON, go to OFF if beep counter < BEEP_NUM, else to IDLE; no trailing gap after the last beep.
REQ-015 SHALL hold buzz at 0 in OFF and IDLE.
REQ-016 SHALL, after BEEP_OFF cycles in OFF, go to ON, increment beep counter, clear tone counter, buzz 0.
REQ-017 SHALL, on trigger while busy (ON or OFF), restart the sequence exactly as in REQ-012.
REQ-018 SHALL start only one sequence for sound held high indefinitely; a new sequence needs a 0-to-1 transition.
REQ-019 SHALL size counters to $clog2(max(param)+1) bits; no counter wraps within a sequence.
REQ-020 SHALL give a total busy length of BEEP_NUM*BEEP_ON + (BEEP_NUM-1)*BEEP_OFF cycles (default 32).

Reset
REQ-021 SHALL, on rst high, immediately force state IDLE, buzz 0, busy 0, sound_d 0, all counters 0, regardless of clk.
REQ-022 SHALL, when rst is released while sound is already 1, start a sequence on the first clock edge (sound_d reset 0).

Configuration
REQ-023 SHALL, with SOUND_BUZZER_CNT_EN defined, add output alarm_cnt (8 bits) counting sequence starts (including restarts), saturating at 255, reset to 0.
REQ-024 SHALL, without SOUND_BUZZER_CNT_EN, omit the alarm_cnt port and its logic entirely.

Structure
REQ-025 SHALL place the FSM state encodings (IDLE=0, ON=1, OFF=2) and the default parameter values in the shared package sound_pkg.
REQ-026 SHALL use one sub-module, tone_gen (clear/enable inputs, HALF_PERIOD divider, buzz output), instantiated once.

Verification
REQ-027 Defaults, rst 1 for 4 cycles, then sound 0-to-1 held 4 cycles -> busy high for exactly 32 cycles, 3 beeps of 8 cycles with 4-cycle gaps, 2 buzz rising edges per beep (6 total).
REQ-028 sound held 1 for 100 cycles -> exactly one 32-cycle sequence, then busy 0 and buzz 0.
REQ-029 Second sound rise during the first OFF gap -> sequence restarts at beep 1, busy stays high for 32 more cycles, buzz 0 on the restart edge.
REQ-030 rst asserted mid-beep with buzz 1 -> buzz and busy go 0 without waiting for clk; no activity after release while sound is 0.
REQ-031 rst released with sound already 1 -> busy high after the first clock edge.
REQ-032 SOUND_BUZZER_CNT_EN defined, 3 separated sound pulses plus 1 restart -> alarm_cnt = 4.
